// File: rtl/counter_event_logger.sv
// Event logger for a free-running counter: timestamps overflow/capture events into a
// small FIFO with a running wrap count, drained over a valid/ready stream.
module counter_event_logger #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           count_value_i,
    input  logic                       overflow_i,
    input  logic                       capture_i,
    input  logic                       clear_i,
    output logic [2+WRAP_W+CNT_W-1:0]  data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic [WRAP_W-1:0]          wrap_cnt_o
);

    localparam int unsigned EW = 2 + WRAP_W + CNT_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_level;
    logic              r_full;
    logic              r_valid;
    logic [EW-1:0]     r_head;
    logic [WRAP_W-1:0] r_wrap;
    logic [DROP_W-1:0] r_drop;

    logic              w_event;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [WRAP_W-1:0] w_wrap_nxt;
    logic [DROP_W-1:0] w_drop_nxt;
    logic [EW-1:0]     w_entry;
    logic [PW-1:0]     w_rd_nxt;
    logic [PW-1:0]     w_wr_nxt;
    logic [PW-1:0]     w_level_nxt;
    logic [EW-1:0]     w_head_nxt;

    // Push/pop/drop decisions and next-state values
    always_comb begin
        w_event     = overflow_i | capture_i;
        w_pop       = r_valid & ready_i;
        w_push      = w_event & (~r_full | w_pop);
        w_drop      = w_event & r_full & ~w_pop;
        w_wrap_nxt  = (overflow_i && (r_wrap != '1)) ? r_wrap + WRAP_W'(1) : r_wrap;
        w_drop_nxt  = (w_drop && (r_drop != '1)) ? r_drop + DROP_W'(1) : r_drop;
        w_entry     = {overflow_i, capture_i, w_wrap_nxt, count_value_i};
        w_rd_nxt    = r_rd_ptr + PW'(w_pop);
        w_wr_nxt    = r_wr_ptr + PW'(w_push);
        w_level_nxt = w_wr_nxt - w_rd_nxt;
        w_head_nxt  = '0;
        // A push landing in the slot that becomes the head must bypass the memory
        if (w_level_nxt != '0) begin
            if (w_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
                w_head_nxt = w_entry;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_head   <= '0;
            r_wrap   <= '0;
            r_drop   <= '0;
        end else if (clear_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_head   <= '0;
            r_wrap   <= '0;
            r_drop   <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == PW'(DEPTH));
            r_valid  <= (w_level_nxt != '0);
            r_head   <= w_head_nxt;
            r_wrap   <= w_wrap_nxt;
            r_drop   <= w_drop_nxt;
        end
    end

    assign data_o     = r_head;
    assign valid_o    = r_valid;
    assign level_o    = r_level;
    assign full_o     = r_full;
    assign drop_cnt_o = r_drop;
    assign wrap_cnt_o = r_wrap;

endmodule

// File: tb/tb_counter_event_logger.sv
// Randomized bench for counter_event_logger against a queue-based reference model,
// with directed scenarios pinning the model to hand-computed values.
module tb_counter_event_logger;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WRAP_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned EW     = 2 + WRAP_W + CNT_W;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [CNT_W-1:0]  count_value_i;
    logic              overflow_i;
    logic              capture_i;
    logic              clear_i;
    logic [EW-1:0]     data_o;
    logic              valid_o;
    logic              ready_i;
    logic [LW-1:0]     level_o;
    logic              full_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic [WRAP_W-1:0] wrap_cnt_o;

    counter_event_logger #(
        .CNT_W(CNT_W), .WRAP_W(WRAP_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .count_value_i(count_value_i), .overflow_i(overflow_i),
        .capture_i(capture_i), .clear_i(clear_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .level_o(level_o), .full_o(full_o), .drop_cnt_o(drop_cnt_o),
        .wrap_cnt_o(wrap_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] q[$];
    int            m_wrap;
    int            m_drop;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_wrap = 0;
        m_drop = 0;
    endtask

    // Reference behaviour for one rising edge, from the sampled inputs
    task automatic model_edge();
        bit pop;
        bit ev;
        if (rst || clear_i) begin
            model_clear();
        end else begin
            pop = (q.size() > 0) && ready_i;
            ev  = overflow_i || capture_i;
            if (overflow_i && m_wrap < 255) m_wrap++;
            if (pop) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH)
                    q.push_back({overflow_i, capture_i, 8'(m_wrap), count_value_i});
                else if (m_drop < 255)
                    m_drop++;
            end
        end
    endtask

    task automatic compare_all();
        logic [EW-1:0] hd;
        hd = (q.size() > 0) ? q[0] : '0;
        chk("valid", 32'(valid_o), 32'(q.size() > 0));
        chk("data", 32'(data_o), 32'(hd));
        chk("level", 32'(level_o), 32'(q.size()));
        chk("full", 32'(full_o), 32'(q.size() == DEPTH));
        chk("drop", 32'(drop_cnt_o), 32'(m_drop));
        chk("wrap", 32'(wrap_cnt_o), 32'(m_wrap));
    endtask

    task automatic drive(input bit ov, input bit cap, input bit clr, input bit rdy,
                         input logic [7:0] cnt);
        overflow_i    = ov;
        capture_i     = cap;
        clear_i       = clr;
        ready_i       = rdy;
        count_value_i = cnt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        compare_all();
        // Event while reset is held must not be stored
        drive(0, 1, 0, 1, 8'h11);
        step();
        step();
        chk("rst_level", 32'(level_o), 32'h0);
        drive(0, 0, 0, 0, 8'h00);
        rst = 1'b0;
        step();
        chk("post_rst_valid", 32'(valid_o), 32'h0);

        // Single capture
        drive(0, 1, 0, 0, 8'h2A);
        step();
        chk("cap_data", 32'(data_o), 32'h1002A);
        chk("cap_level", 32'(level_o), 32'h1);
        drive(0, 0, 0, 1, 8'h00);
        step();
        chk("cap_pop_valid", 32'(valid_o), 32'h0);

        // Overflow with capture, then a second overflow much later
        drive(1, 1, 0, 0, 8'h00);
        step();
        chk("ovf_data", 32'(data_o), 32'h30100);
        chk("ovf_wrap", 32'(wrap_cnt_o), 32'h1);
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 255; i++) step();
        drive(1, 0, 0, 0, 8'h00);
        step();
        chk("ovf2_wrap", 32'(wrap_cnt_o), 32'h2);
        drive(0, 0, 0, 1, 8'h00);
        step();
        chk("ovf2_data", 32'(data_o), 32'h20200);
        step();

        // Fill and drop
        drive(0, 0, 1, 0, 8'h00);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 8'(i));
            step();
            if (i == 7) chk("fill_full", 32'(full_o), 32'h1);
        end
        chk("fill_level", 32'(level_o), 32'h8);
        chk("fill_drop", 32'(drop_cnt_o), 32'h2);
        chk("fill_head", 32'(data_o[7:0]), 32'h0);

        // Full with simultaneous push and pop
        drive(0, 1, 0, 1, 8'h55);
        step();
        chk("pp_level", 32'(level_o), 32'h8);
        chk("pp_drop", 32'(drop_cnt_o), 32'h2);
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_cnt", 32'(data_o[7:0]), (i == 8) ? 32'h55 : 32'(i));
            step();
        end
        chk("drain_empty", 32'(valid_o), 32'h0);

        // Clear collides with a capture
        drive(1, 0, 0, 0, 8'h07);
        for (int i = 0; i < 3; i++) step();
        chk("clr_pre_level", 32'(level_o), 32'h3);
        chk("clr_pre_wrap", 32'(wrap_cnt_o), 32'h3);
        drive(0, 1, 1, 1, 8'h99);
        step();
        chk("clr_level", 32'(level_o), 32'h0);
        chk("clr_valid", 32'(valid_o), 32'h0);
        chk("clr_wrap", 32'(wrap_cnt_o), 32'h0);
        chk("clr_drop", 32'(drop_cnt_o), 32'h0);

        // Saturation of both counters
        drive(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 300; i++) step();
        chk("sat_wrap", 32'(wrap_cnt_o), 32'hFF);
        chk("sat_drop", 32'(drop_cnt_o), 32'hFF);
        drive(0, 0, 1, 0, 8'h00);
        step();

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
                  8'($urandom));
            if (i % 500 == 250) begin
                drive(0, 0, 0, 0, 8'h00);
                for (int k = 0; k < 12; k++) step();
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_event_logger.md
# counter_event_logger

Downstream consumer of the simple counter's `count_value_o` / `overflow_o` outputs. Timestamps each counter overflow or software capture request into a small FIFO, together with a running wrap count. Drains entries through a valid/ready stream so a slower monitor or bus master can read them without losing order. Drops on a full FIFO are counted, never silent.

## Interface
- `CNT_W`, default 8: width of the counter value being logged.
- `WRAP_W`, default 8: width of the overflow (wrap) counter.
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `DROP_W`, default 8: width of the dropped-event counter.
- Entry width `EW = 2 + WRAP_W + CNT_W`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `count_value_i` in CNT_W: counter value, sampled every cycle.
- `overflow_i` in 1: overflow pulse from the counter, one cycle per wrap.
- `capture_i` in 1: request to log the current count.
- `clear_i` in 1: synchronous flush.
- `data_o` out EW: head entry, packed as `{ovf, cap, wrap[WRAP_W-1:0], count[CNT_W-1:0]}`.
- `valid_o` out 1: head entry is valid.
- `ready_i` in 1: consumer accepts the head entry.
- `level_o` out clog2(DEPTH)+1: number of stored entries.
- `full_o` out 1: level equals DEPTH.
- `drop_cnt_o` out DROP_W: saturating count of dropped events.
- `wrap_cnt_o` out WRAP_W: saturating count of overflows since reset or clear.

## Operation
- **Event:** any cycle with `overflow_i | capture_i`. One event produces at most one entry.
- **Entry fields:**
  - `ovf = overflow_i`, `cap = capture_i`.
  - `count = count_value_i` in the same cycle.
  - `wrap` = the wrap counter value after this cycle's increment, saturated at the maximum.
- **Wrap counter:** increments on `overflow_i` and saturates at 2^WRAP_W-1. Output on `wrap_cnt_o`.
- **Pop:** `valid_o & ready_i`. Advances the read pointer. `ready_i` while `valid_o = 0` has no effect.
- **Push:** event and (not full, or pop in the same cycle).
  - Full with simultaneous pop: the push is accepted and the level stays at DEPTH.
- **Drop:** event while full and no pop. The entry is discarded and `drop_cnt_o` increments, saturating at 2^DROP_W-1.
- **Clear:** `clear_i` has priority over everything else in its cycle.
  - Pointers, level, `wrap_cnt_o` and `drop_cnt_o` go to 0.
  - A same-cycle event and a same-cycle pop are ignored.
- **Head data:** `data_o = valid_o ? mem[rd_ptr] : 0`. Head data is stable while `valid_o` is high and `ready_i` is low.
- **Pointers:** clog2(DEPTH)+1 bits, natural wrap.
  - Empty: pointers equal.
  - Full: pointers differ only in the MSB.

## Timing
- **Reset:** while `rst` is high, all of these are 0: `valid_o`, `data_o`, `level_o`, `full_o`, `drop_cnt_o`, `wrap_cnt_o`, and the pointers. Memory contents are don't-care. Assertion is asynchronous.
- **Reset mid-operation:** all stored entries are lost. The first edge after deassertion behaves as a normal cycle.
- **Latency:**
  - An event at edge N into an empty FIFO makes `valid_o = 1` with that entry on `data_o` after edge N (visible in cycle N+1).
  - Pop at edge N: the next entry (or `valid_o = 0`) is visible after edge N.
- **Throughput:** one push and one pop per cycle, sustained.
- **Pop then push:** an entry popped at edge N frees its slot for a push at that same edge.
- **Counter updates:** `wrap_cnt_o`, `drop_cnt_o` and `level_o` update at the same edge as the event or pop that causes them.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Reset:** hold `rst` high for 2 cycles, then drive events.
  - Expected: all outputs 0 during reset, including an event driven while reset is high.
  - Expected: `valid_o` stays 0 until the first event after deassertion.
- **Single capture:** `capture_i` pulsed with `count_value_i = 8'h2A`, `ready_i = 0`.
  - Expected next cycle: `valid_o = 1`, `data_o = {0,1,8'h00,8'h2A}`, `level_o = 1`.
  - Raise `ready_i`. Expected next cycle: `valid_o = 0`.
- **Overflow with simultaneous capture:** first overflow, with `capture_i = 1` and count 0.
  - Expected entry: `{1,1,8'h01,8'h00}`, `wrap_cnt_o = 1`.
  - A second overflow 256 cycles later gives `wrap = 2`.
- **Fill and drop:** `ready_i = 0`, 10 captures with counts 0..9.
  - Expected: `full_o = 1` after the 8th capture, `level_o = 8`, `drop_cnt_o = 2`.
  - Drain: `data_o` shows counts 0..7 in order.
- **Full with simultaneous push and pop:** FIFO full, capture with count 8'h55 and `ready_i = 1` in the same cycle.
  - Expected: `level_o` stays 8, `drop_cnt_o` unchanged.
  - Expected: the last drained entry has count 8'h55.
- **Clear collision:** 3 entries stored, `wrap_cnt_o = 3`, then `clear_i` with a capture in the same cycle.
  - Expected next cycle: `level_o = 0`, `valid_o = 0`, `wrap_cnt_o = 0`, `drop_cnt_o = 0`, capture not stored.
